// File: rtl/mult_coe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_coe_ctrl_if
//  Purpose  : Host-side configuration bus of the coefficient controller.
//             The host writes staging coefficients, commits them and
//             observes the busy flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface mult_coe_ctrl_if #(
    parameter int COE_WIDTH = 16,
    parameter int COE_COUNT = 3
);
    localparam int IDX_W = (COE_COUNT > 1) ? $clog2(COE_COUNT) : 1;

    logic                 cfg_wr_i;
    logic [IDX_W-1:0]     cfg_idx_i;
    logic [COE_WIDTH-1:0] cfg_data_i;
    logic                 cfg_commit_i;
    logic                 cfg_busy_o;

    // Host side: drives writes and commits, watches busy
    modport master (
        output cfg_wr_i,
        output cfg_idx_i,
        output cfg_data_i,
        output cfg_commit_i,
        input  cfg_busy_o
    );

    // Controller side
    modport slave (
        input  cfg_wr_i,
        input  cfg_idx_i,
        input  cfg_data_i,
        input  cfg_commit_i,
        output cfg_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/mult_coe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_coe_ctrl
//  Purpose  : Coefficient controller for the mult_v1 pixel multiplier.
//             The host fills a staging bank and commits it; the applied set
//             (coe_o) only changes on a frame end (vs_i falling), so a frame
//             is never processed with mixed coefficients.
//  Options  : COE_RAMP_EN - when defined, each frame end moves every
//             coefficient toward its staged value by at most RAMP_STEP.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_coe_ctrl #(
    parameter int                   COE_WIDTH = 16,
    parameter int                   COE_COUNT = 3,
    parameter logic [COE_WIDTH-1:0] COE_INIT  = 16'h400
`ifdef COE_RAMP_EN
    ,
    parameter logic [COE_WIDTH-1:0] RAMP_STEP = 16'h40
`endif
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    mult_coe_ctrl_if.slave                      cfg,
    input  wire logic                           vs_i,
    output logic [COE_WIDTH*COE_COUNT-1:0]      coe_o,
    output logic                                upd_o
);

    localparam int IDX_W = (COE_COUNT > 1) ? $clog2(COE_COUNT) : 1;
    localparam int VEC_W = COE_WIDTH * COE_COUNT;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
`ifdef COE_RAMP_EN
    localparam logic [1:0] S_RAMP  = 2'd2;
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_vs_q;
    logic             r_busy;
    logic             r_upd;
    logic [VEC_W-1:0] r_stg;
    logic [VEC_W-1:0] r_coe;
    logic [VEC_W-1:0] w_coe_nxt;

    logic             w_fe;
    logic [IDX_W:0]   w_idx_ext;
    logic             w_idx_ok;
    logic             w_stg_we;
    logic             w_apply;
    logic             w_upd_nxt;
    logic             w_busy_nxt;

    // Frame end: stream was active last cycle and is in blanking now
    assign w_fe      = r_vs_q & ~vs_i;
    assign w_idx_ext = {1'b0, cfg.cfg_idx_i};
    assign w_idx_ok  = (w_idx_ext < (IDX_W+1)'(COE_COUNT));

`ifdef COE_RAMP_EN
    logic w_all_eq;

    // Per-lane bounded step toward the staged value; never overshoots
    for (genvar k = 0; k < COE_COUNT; k++) begin : g_lane
        logic [COE_WIDTH-1:0] w_cur;
        logic [COE_WIDTH-1:0] w_tgt;
        logic [COE_WIDTH-1:0] w_nxt;

        assign w_cur = r_coe[COE_WIDTH*k +: COE_WIDTH];
        assign w_tgt = r_stg[COE_WIDTH*k +: COE_WIDTH];

        // Clamp the move to RAMP_STEP in whichever direction is needed
        always_comb begin
            w_nxt = w_tgt;
            if (w_tgt > w_cur) begin
                if ((w_tgt - w_cur) > RAMP_STEP) w_nxt = w_cur + RAMP_STEP;
            end else begin
                if ((w_cur - w_tgt) > RAMP_STEP) w_nxt = w_cur - RAMP_STEP;
            end
        end

        assign w_coe_nxt[COE_WIDTH*k +: COE_WIDTH] = w_nxt;
    end

    // Ramp finishes on the frame end whose step lands on the staged set
    assign w_all_eq = (w_coe_nxt == r_stg);
`else
    // Whole staged set is applied in one step
    assign w_coe_nxt = r_stg;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic: commit arms, frame end applies
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cfg.cfg_commit_i) w_state_nxt = S_ARMED;
`ifdef COE_RAMP_EN
            S_ARMED: if (w_fe) w_state_nxt = w_all_eq ? S_IDLE : S_RAMP;
            S_RAMP:  if (w_fe && w_all_eq) w_state_nxt = S_IDLE;
`else
            S_ARMED: if (w_fe) w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: staging writes only when idle, updates only on frame end
    always_comb begin
        w_stg_we  = 1'b0;
        w_apply   = 1'b0;
        w_upd_nxt = 1'b0;
        case (r_state)
            S_IDLE: w_stg_we = cfg.cfg_wr_i & w_idx_ok;
            S_ARMED: begin
                w_apply   = w_fe;
`ifdef COE_RAMP_EN
                w_upd_nxt = w_fe & w_all_eq;
`else
                w_upd_nxt = w_fe;
`endif
            end
`ifdef COE_RAMP_EN
            S_RAMP: begin
                w_apply   = w_fe;
                w_upd_nxt = w_fe & w_all_eq;
            end
`endif
            default: ;
        endcase
    end

    assign w_busy_nxt = (w_state_nxt != S_IDLE);

    // Registered frame-valid, busy flag and update pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vs_q <= 1'b0;
            r_busy <= 1'b0;
            r_upd  <= 1'b0;
        end else begin
            r_vs_q <= vs_i;
            r_busy <= w_busy_nxt;
            r_upd  <= w_upd_nxt;
        end
    end

    // Staging bank: host writes land on the addressed lane
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stg <= {COE_COUNT{COE_INIT}};
        end else begin
            for (int k = 0; k < COE_COUNT; k++) begin
                if (w_stg_we && (w_idx_ext == (IDX_W+1)'(k)))
                    r_stg[COE_WIDTH*k +: COE_WIDTH] <= cfg.cfg_data_i;
            end
        end
    end

    // Applied coefficient set, changes only on a frame end while armed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_coe <= {COE_COUNT{COE_INIT}};
        else if (w_apply) r_coe <= w_coe_nxt;
    end

    assign coe_o          = r_coe;
    assign upd_o          = r_upd;
    assign cfg.cfg_busy_o = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_coe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_coe_ctrl
//  Purpose  : Self-checking bench for mult_coe_ctrl: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a pending-commit behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_coe_ctrl;

    localparam int          W    = 16;
    localparam int          N    = 3;
    localparam logic [15:0] INIT = 16'h400;
    localparam logic [15:0] STEP = 16'h40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vs  = 1'b0;
    logic [47:0] coe;
    logic        upd;

    mult_coe_ctrl_if #(.COE_WIDTH(W), .COE_COUNT(N)) cfg ();

    mult_coe_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .cfg   (cfg),
        .vs_i  (vs),
        .coe_o (coe),
        .upd_o (upd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a pending flag plus the two coefficient banks
    // ------------------------------------------------------------------
    logic [15:0] m_coe [N];
    logic [15:0] m_stg [N];
    bit          m_pend, m_busy, m_upd, m_vs;

    function automatic logic [15:0] move_toward(input logic [15:0] cur, input logic [15:0] tgt);
`ifdef COE_RAMP_EN
        if (tgt > cur) return ((tgt - cur) > STEP) ? cur + STEP : tgt;
        else           return ((cur - tgt) > STEP) ? cur - STEP : tgt;
`else
        return tgt;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                m_coe[k] = INIT;
                m_stg[k] = INIT;
            end
            m_pend = 0; m_busy = 0; m_upd = 0; m_vs = 0;
        end else begin
            bit fe;
            bit done;
            fe    = m_vs && !vs;
            m_vs  = vs;
            m_upd = 0;
            if (!m_pend) begin
                if (cfg.cfg_wr_i && cfg.cfg_idx_i < N) m_stg[cfg.cfg_idx_i] = cfg.cfg_data_i;
                if (cfg.cfg_commit_i) m_pend = 1;
            end else if (fe) begin
                done = 1;
                for (int k = 0; k < N; k++) begin
                    m_coe[k] = move_toward(m_coe[k], m_stg[k]);
                    if (m_coe[k] != m_stg[k]) done = 0;
                end
                if (done) begin
                    m_pend = 0;
                    m_upd  = 1;
                end
            end
            m_busy = m_pend;
        end
    end

    // Compare process: every cycle out of reset, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            chk("model coe_o", coe, {m_coe[2], m_coe[1], m_coe[0]});
            chk("model cfg_busy_o", 48'(cfg.cfg_busy_o), 48'(m_busy));
            chk("model upd_o", 48'(upd), 48'(m_upd));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_wr(input logic [1:0] idx, input logic [15:0] data);
        cfg.cfg_wr_i   = 1'b1;
        cfg.cfg_idx_i  = idx;
        cfg.cfg_data_i = data;
        cyc(1);
        cfg.cfg_wr_i   = 1'b0;
    endtask

    task automatic do_commit();
        cfg.cfg_commit_i = 1'b1;
        cyc(1);
        cfg.cfg_commit_i = 1'b0;
    endtask

    // Active frame of n cycles, then the edge that sees the fall
    task automatic frame(input int n);
        vs = 1'b1;
        cyc(n);
        vs = 1'b0;
        cyc(1);
    endtask

    initial begin
`ifdef COE_RAMP_EN
        logic [15:0] ramp_exp [4];
        ramp_exp = '{16'h440, 16'h480, 16'h4C0, 16'h500};
`endif
        cfg.cfg_wr_i     = 1'b0;
        cfg.cfg_idx_i    = '0;
        cfg.cfg_data_i   = '0;
        cfg.cfg_commit_i = 1'b0;

        // 1: reset state and stability after release
        cyc(3);
        chk("reset coe_o", coe, 48'h0400_0400_0400);
        chk("reset busy", 48'(cfg.cfg_busy_o), 48'h0);
        chk("reset upd", 48'(upd), 48'h0);
        rst = 1'b1;
        cyc(10);
        chk("idle coe_o stable", coe, 48'h0400_0400_0400);
        chk("idle busy", 48'(cfg.cfg_busy_o), 48'h0);

`ifndef COE_RAMP_EN
        // 2: commit during active frame, applied at the frame end
        vs = 1'b1;
        cyc(2);
        do_wr(2'd2, 16'h0800);
        do_commit();
        chk("t2 busy after commit", 48'(cfg.cfg_busy_o), 48'h1);
        cyc(5);
        chk("t2 coe held mid-frame", coe, 48'h0400_0400_0400);
        vs = 1'b0;
        cyc(1);
        chk("t2 coe applied", coe, 48'h0800_0400_0400);
        chk("t2 upd pulse", 48'(upd), 48'h1);
        chk("t2 busy cleared", 48'(cfg.cfg_busy_o), 48'h0);
        cyc(1);
        chk("t2 upd single", 48'(upd), 48'h0);

        // 3: commit during blanking waits for the following frame end
        do_wr(2'd0, 16'h0300);
        do_commit();
        cyc(2);
        vs = 1'b1;
        cyc(1);
        chk("t3 coe at vs rise", coe, 48'h0800_0400_0400);
        chk("t3 busy at vs rise", 48'(cfg.cfg_busy_o), 48'h1);
        cyc(4);
        vs = 1'b0;
        cyc(1);
        chk("t3 coe applied", coe, 48'h0800_0400_0300);
        chk("t3 upd pulse", 48'(upd), 48'h1);

        // 4: writes while busy and out-of-range index are dropped
        vs = 1'b1;
        cyc(1);
        do_commit();
        do_wr(2'd0, 16'h0123);
        cyc(2);
        vs = 1'b0;
        cyc(1);
        chk("t4 busy write dropped", coe, 48'h0800_0400_0300);
        chk("t4 equal-set upd", 48'(upd), 48'h1);
        do_wr(2'd3, 16'h0777);
        cfg.cfg_wr_i     = 1'b1;
        cfg.cfg_idx_i    = 2'd1;
        cfg.cfg_data_i   = 16'h0200;
        cfg.cfg_commit_i = 1'b1;
        cyc(1);
        cfg.cfg_wr_i     = 1'b0;
        cfg.cfg_commit_i = 1'b0;
        frame(3);
        chk("t4 wr+commit applied", coe, 48'h0800_0200_0300);
        chk("t4 upd pulse", 48'(upd), 48'h1);
`else
        // 5: ramp up in four frame ends, then a short decrease
        do_wr(2'd0, 16'h0500);
        do_commit();
        for (int f = 0; f < 4; f++) begin
            frame(3);
            chk("t5 ramp lane0", 48'(coe[15:0]), 48'(ramp_exp[f]));
            chk("t5 ramp upd", 48'(upd), 48'(f == 3));
            chk("t5 ramp busy", 48'(cfg.cfg_busy_o), 48'(f < 3));
        end
        cyc(2);
        do_wr(2'd0, 16'h04F0);
        do_commit();
        frame(3);
        chk("t5 down no overshoot", coe, 48'h0400_0400_04F0);
        chk("t5 down upd", 48'(upd), 48'h1);

        // 6: reset in the middle of a ramp
        cyc(1);
        do_wr(2'd0, 16'h0500);
        do_commit();
        frame(3);
        frame(3);
        chk("t6 mid-ramp lane0", 48'(coe[15:0]), 48'h0480);
        vs = 1'b1;
        cyc(2);
        #2 rst = 1'b0;
        #1;
        chk("t6 async reset coe", coe, 48'h0400_0400_0400);
        chk("t6 async reset busy", 48'(cfg.cfg_busy_o), 48'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vs = (i < 4);
            cyc(1);
            chk("t6 no upd after reset", 48'(upd), 48'h0);
            chk("t6 coe stays init", coe, 48'h0400_0400_0400);
        end
`endif

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) vs = ~vs;
            cfg.cfg_wr_i     = ($urandom_range(0, 3) == 0);
            cfg.cfg_idx_i    = 2'($urandom_range(0, 3));
            cfg.cfg_data_i   = 16'(32'h0300 + $urandom_range(0, 32'h0200));
            cfg.cfg_commit_i = ($urandom_range(0, 11) == 0);
            cyc(1);
        end
        cfg.cfg_wr_i     = 1'b0;
        cfg.cfg_commit_i = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
